// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared sizes, types and key-map helpers for the matrix scanner
package key_scan_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef logic [1:0]                   col_t;
    typedef logic [NUM_ROWS*NUM_COLS-1:0] map_t;

    function automatic logic is_onehot(input map_t m);
        return (m != '0) && ((m & (m - map_t'(1))) == '0);
    endfunction

    function automatic logic [KEY_W-1:0] key_idx(input map_t m);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS*NUM_COLS; i++)
            if (m[i]) idx = KEY_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/key_scan_sync2.sv
// sync2: parameterized-width two-flop synchronizer with async active-low reset
module sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_s1, r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
endmodule

// File: rtl/key_scan.sv
// key_scan: 4x4 active-low matrix scanner with frame debounce and single-key press pulses
module key_scan
    import key_scan_pkg::*;
#(
    parameter int SCAN_DELAY     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_down
);
    logic [NUM_ROWS-1:0] w_rows;
    logic [15:0]         r_cnt;
    col_t                r_col;
    map_t                r_snap, r_prev, r_acc, w_snap;
    logic [3:0]          r_stable, w_stable;
    logic [KEY_W-1:0]    r_key;
    logic                r_valid, r_down;
    logic                w_tc, w_fend, w_accept, w_press;

    sync2 #(.W(NUM_ROWS), .RST_VAL(4'b1111)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row_n),
        .o_q   (w_rows)
    );

    // w_snap is the frame map with the current column's rows merged in, so the
    // debounce at frame end sees column 3 without waiting an extra cycle
    always_comb begin
        w_tc   = r_cnt == 16'(SCAN_DELAY - 1);
        w_fend = w_tc && (r_col == 2'd3);
        w_snap = r_snap;
        for (int r = 0; r < NUM_ROWS; r++)
            w_snap[NUM_COLS*r + int'(r_col)] = ~w_rows[r];
        w_stable = (w_snap != r_prev) ? 4'd1 :
                   (r_stable == 4'(DEBOUNCE_SCANS)) ? r_stable : r_stable + 4'd1;
        w_accept = w_fend && (w_stable == 4'(DEBOUNCE_SCANS));
        w_press  = w_accept && (r_acc == '0) && is_onehot(w_snap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_col    <= '0;
            r_snap   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_acc    <= '0;
            r_key    <= '0;
            r_valid  <= 1'b0;
            r_down   <= 1'b0;
        end else begin
            r_valid <= w_press;
            r_cnt   <= w_tc ? '0 : r_cnt + 16'd1;
            if (w_tc) begin
                r_snap <= w_snap;
                r_col  <= r_col + 2'd1;
            end
            if (w_fend) begin
                r_prev   <= w_snap;
                r_stable <= w_stable;
            end
            if (w_accept) begin
                r_acc  <= w_snap;
                r_down <= w_snap != '0;
            end
            if (w_press) r_key <= key_idx(w_snap);
        end
    end

    assign col_n     = ~(4'b0001 << r_col);
    assign key       = r_key;
    assign key_valid = r_valid;
    assign key_down  = r_down;
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: scoreboard bench for key_scan with SCAN_DELAY=4, DEBOUNCE_SCANS=3
module tb_key_scan;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n, col_n, key;
    logic        key_valid, key_down;
    logic [15:0] keys;
    int          cyc;
    int          total = 0;
    int          bad = 0;
    logic        prev_valid = 1'b0;

    typedef struct {
        logic [3:0] k;
        int         c;
    } exp_t;
    exp_t q[$];

    key_scan #(.SCAN_DELAY(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                if (q.size() == 0) chk("spurious_pulse", 32'(key_valid), 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("key", 32'(key), 32'(e.k));
                    chk("pulse_cycle", cyc, e.c);
                    chk("down_at_pulse", 32'(key_down), 32'd1);
                end
                if (prev_valid) chk("double_pulse", 32'(prev_valid), 32'd0);
            end
            prev_valid = key_valid;
        end else prev_valid = 1'b0;
    end

    task automatic push(input logic [3:0] k, input int c);
        exp_t e;
        e.k = k;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic frames(input int n);
        repeat (16*n) @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        keys  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col_n), 32'hE);
        chk("rst_key", 32'(key), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_down", 32'(key_down), 32'd0);

        // clean single press, r2 c1 -> key 9
        rst_n = 1'b1;
        keys  = 16'(1) << 9;
        push(4'd9, 48);
        frames(10);
        chk("t2_q_empty", 32'(q.size()), 32'd0);
        chk("t2_down", 32'(key_down), 32'd1);
        chk("t2_key_hold", 32'(key), 32'd9);

        // async reset mid-dwell, then column stepping
        repeat (6) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_col", 32'(col_n), 32'hE);
        chk("async_key", 32'(key), 32'd0);
        chk("async_valid", 32'(key_valid), 32'd0);
        chk("async_down", 32'(key_down), 32'd0);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("col_step", 32'(col_n), 32'(4'(~(4'b0001 << ((k/4) % 4)))));
            @(negedge clk);
        end

        // bounce for 6 frames, then hold
        restart();
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 16'(1) << 9 : 16'h0;
            frames(1);
        end
        keys = 16'(1) << 9;
        push(4'd9, 144);
        frames(5);
        chk("t3_q_empty", 32'(q.size()), 32'd0);

        // multi-key: r0c0 + r3c3, then drop r3c3, release, then r0c3
        restart();
        keys = 16'h8001;
        frames(4);
        chk("t4_multi_down", 32'(key_down), 32'd1);
        keys = 16'h0001;
        frames(4);
        chk("t4_one_down", 32'(key_down), 32'd1);
        keys = '0;
        frames(3);
        keys = 16'h0008;
        push(4'd3, 224);
        frames(5);
        chk("t4_q_empty", 32'(q.size()), 32'd0);
        chk("t4_key", 32'(key), 32'd3);

        // reset mid-debounce with r1c2 held
        restart();
        keys = 16'(1) << 6;
        frames(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_down", 32'(key_down), 32'd0);
        rst_n = 1'b1;
        push(4'd6, 48);
        frames(5);
        chk("t5_q_empty", 32'(q.size()), 32'd0);

        // release and re-press r3c0
        restart();
        keys = 16'(1) << 12;
        push(4'd12, 48);
        frames(4);
        keys = '0;
        frames(4);
        chk("t6_released", 32'(key_down), 32'd0);
        keys = 16'(1) << 12;
        push(4'd12, 176);
        frames(4);
        chk("t6_q_empty", 32'(q.size()), 32'd0);
        chk("t6_down", 32'(key_down), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_scan.md
# key_scan

Multiplexed 4×4 button-matrix scanner for the Genius board; the input-side counterpart of the multiplexed seven-segment display driver. It strobes one active-low column at a time with a fixed dwell, samples the active-low rows, and debounces whole-matrix frames. It reports a single clean key code with a one-cycle valid pulse to the game controller.

## Interface

Parameters:
- SCAN_DELAY, 50000: dwell per column in clk cycles; legal range 4..65535.
- DEBOUNCE_SCANS, 4: consecutive identical frames needed to accept a matrix state; legal range 2..15.

Ports:
- clk, input, 1: single system clock; all logic on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- row_n, input, 4: matrix rows; asynchronous, pulled up; 0 = pressed key in the driven column.
- col_n, output, 4: column strobes; exactly one bit low at all times.
- key, output, 4: code of the accepted key, computed as 4*row + col.
- key_valid, output, 1: one-cycle pulse when a new key is accepted.
- key_down, output, 1: level, 1 while the accepted matrix state has any key pressed.

## Operation

- Rows pass through a 2-flop synchronizer before any use.
- Column scan:
  - The dwell counter counts 0..SCAN_DELAY-1.
  - At terminal count, the synchronized rows are sampled into 4 bits of the frame snapshot at the current column's position.
  - The column index then advances 0→1→2→3→0, wrapping, and col_n = ~(1 << col).
- Frame: a frame is complete when column 3 is sampled. Snapshot = 16-bit pressed map, bit index 4*row+col, 1 = pressed.
- Debounce, evaluated at frame end:
  - If the snapshot differs from the previous frame's snapshot, stable_cnt := 1.
  - Otherwise stable_cnt := min(stable_cnt+1, DEBOUNCE_SCANS).
  - When stable_cnt becomes DEBOUNCE_SCANS, the accepted map := snapshot.
- Key events, on each update of the accepted map:
  - If old map == 0 and new map has exactly one bit set: key := that bit's index; key_valid := 1 for one cycle.
  - All other transitions produce no pulse: zero→multiple, multiple→one, one→one. key holds its last value.
  - No auto-repeat. A held key yields exactly one pulse; the next pulse requires an accepted all-released map first.
- key_down = (accepted map != 0), registered.

## Timing

- Reset values:
  - col_n = 4'b1110.
  - key = 0, key_valid = 0, key_down = 0.
  - Dwell counter, column index, snapshot, previous snapshot, stable_cnt and accepted map all 0.
- A reset assertion mid-frame or mid-debounce discards all partial state immediately. No pulse may be emitted as a result of reset.
- Column period: SCAN_DELAY cycles. Frame period: 4*SCAN_DELAY cycles.
- Sample point: last cycle of the dwell. The 2-cycle synchronizer latency is covered by the SCAN_DELAY ≥ 4 minimum.
- Latency from a clean press present over full frames to the key_valid pulse:
  - Acceptance occurs at the end of the DEBOUNCE_SCANS-th identical frame.
  - key_valid and key_down are asserted on the cycle after that frame-end edge.
  - key is valid in the same cycle as key_valid.
- key_valid is never high on two consecutive cycles. Minimum spacing between pulses is 2*DEBOUNCE_SCANS frames (release, then new press).

## Structure

- Shared package key_scan_pkg:
  - NUM_ROWS = 4, NUM_COLS = 4.
  - KEY_W = 4.
  - Column-index typedef, 2 bits.
  - Key-map typedef, 16 bits.
- One sub-module: sync2, a parameterized-width 2-flop synchronizer with async active-low reset. It is instantiated for row_n with reset value 4'b1111.
- Scan counter, snapshot/debounce and one-hot detection stay in key_scan.

## Test plan

Bench parameters: SCAN_DELAY=4, DEBOUNCE_SCANS=3 (frame = 16 cycles).

1. Reset behaviour:
   - Assert rst_n low mid-dwell → col_n=1110 and all outputs 0 asynchronously.
   - After release → col_n steps 1110, 1101, 1011, 0111, 1110, holding each value for 4 cycles.
2. Clean single press: drive row 2 low only while col_n[1]=0, held 10 frames → exactly one key_valid pulse, with key=9 and key_down=1, at the first cycle after frame 3 ends. No further pulses.
3. Bounce: alternate row 2 (col 1) between pressed and released every frame for 6 frames, then hold pressed → no pulse during bouncing; a single pulse after the 3rd steady frame.
4. Multi-key:
   - Press (r0,c0) and (r3,c3) together → key_down=1, no pulse.
   - Release (r3,c3) → still no pulse.
   - Release all, wait 3 frames, then press (r0,c3) → pulse with key=3.
5. Reset mid-debounce: press (r1,c2) and assert rst_n for 1 cycle after 2 identical frames → no pulse. After release, the pulse with key=6 arrives 3 full frames later.
6. Release/re-press: press (r3,c0), release for 3+ frames (key_down falls), press again → two separate pulses, both with key=12.
